write_nalu: RTL and testbench
=============================

Name: write_nalu

Overview:
Annex-B NAL unit writer, the transmit-side counterpart of the bitstream NALU reader. It takes a NAL header (type and ref_idc) plus an RBSP byte stream using the same 9-bit {last, byte} format the reader emits. It outputs an Annex-B byte stream: start code, header byte, then payload with emulation-prevention 0x03 bytes inserted. It sits between the encoder's RBSP producer and the stream memory, and drives the byte-write address.

Parameters:
ALWAYS_LONG_SC, 0, 1 = always emit 4-byte start code 00 00 00 01; 0 = 4-byte only for nal_unit_type 7/8, else 3-byte 00 00 01
ADDR_W, 32, width of stream_mem_addr

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state
nal_start  in  1  pulse in IDLE: begin new NAL, capture header fields
nal_unit_type  in  5  header type, sampled on accepted nal_start
nal_ref_idc  in  2  header ref_idc, sampled on accepted nal_start
rbsp_data_in  in  9  bit8 = last RBSP byte of NAL, bits7:0 = byte
rbsp_valid_in  in  1  rbsp_data_in valid
rbsp_ready_out  out  1  byte accepted when valid&&ready
stream_data_out  out  8  Annex-B byte
stream_valid_out  out  1  stream_data_out valid
stream_ready_in  in  1  sink accepts byte
stream_mem_addr  out  ADDR_W  address of current output byte
busy  out  1  state != IDLE or output register occupied
nal_done  out  1  1-cycle pulse on handshake of final byte of a NAL

Behaviour:
- Reset values: all outputs 0, state IDLE, zero_cnt 0, header reg 0.
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Output stage: one registered byte, valid_r and last_r.
  - stream_valid_out = valid_r && ena.
  - Transfer = stream_valid_out && stream_ready_in; it clears valid_r unless a new byte loads the same cycle.
  - Load allowed when ena && (!valid_r || stream_ready_in). No bubbles at full throughput: 1 byte/cycle.
- stream_mem_addr increments by 1 on each transfer and wraps naturally at 2^ADDR_W.
- Header byte = {1'b0, nal_ref_idc, nal_unit_type}. The forbidden bit is forced 0.
- States:
  - IDLE: nal_start && ena -> capture header, sc_cnt = 0, go SC. nal_start outside IDLE is ignored.
  - SC: load 0x00 per load slot until 2 (short) or 3 (long) zeros are loaded, then load 0x01 -> HDR. Start-code bytes never trigger emulation prevention.
  - HDR: load header byte, zero_cnt = 0 -> PAY.
  - PAY: need_epb = rbsp_valid_in && zero_cnt==2 && rbsp_data_in[7:0] <= 8'h03.
    - need_epb: load 0x03, zero_cnt = 0, rbsp_ready_out = 0 (the byte is accepted in a later slot).
    - Otherwise: rbsp_ready_out = load-allowed. An accepted byte is loaded; zero_cnt = (byte==0) ? min(zero_cnt+1, 2) : 0.
    - Accepted byte with bit8 = 1: if byte == 0x00 go TAIL, else go IDLE with last_r = 1.
  - TAIL: load 0x03 with last_r = 1 -> IDLE. The NAL must not end in 0x00.
- rbsp_ready_out is 0 outside PAY, when ena = 0, and while need_epb.
- nal_done fires on the transfer with last_r = 1. A new nal_start is accepted in IDLE even while the final byte is still pending in the output register; SC loads wait for the load slot.
- ena = 0: no state, address, or counter change; stream_valid_out and rbsp_ready_out forced 0.
- Reset mid-NAL: immediate return to reset values; any partial NAL is abandoned. Downstream resynchronises on the next start code.
- Arithmetic: zero_cnt is 2-bit and saturates at 2. sc_cnt is 2-bit.

Decomposition:
- Shared package (nalu_pkg): start-code constants 24'h000001 and 32'h00000001, EPB byte 8'h03, NAL type constants (1, 5, 7, 8), state encoding localparams.
- The reader's constants move into the same package.
- Natural sub-module: nalu_epb_insert, the PAY zero-counter/insert decision plus the output register. The rest is a single FSM in write_nalu.

Test Plan:
- Type 7, ref_idc 3, RBSP {42, 00, 1F, last:E9}, sink always ready:
  - output 00 00 00 01 67 42 00 1F E9;
  - addr ends at 9;
  - nal_done on the 9th byte.
- Type 1, ref_idc 2, RBSP {00, 00, 01, 00, 00, last:80}:
  - output 00 00 01 41 00 00 03 01 00 00 80 (no EPB before 0x80);
  - rbsp_ready_out low for exactly 1 cycle at the EPB.
- Type 5, RBSP {00, 00, 00, last:00}:
  - EPB before the 3rd zero;
  - trailing 03 appended: 00 00 01 65 00 00 03 00 00 03.
- Same NAL with stream_ready_in toggling 1010 and ena low for 3 cycles mid-payload:
  - byte sequence identical;
  - no valid during ena = 0;
  - addr equals byte count.
- ALWAYS_LONG_SC = 1, type 1:
  - 4-byte start code;
  - nal_start asserted mid-NAL is ignored;
  - back-to-back NALs are contiguous with no idle cycle.
- rst_n asserted mid-payload:
  - all outputs 0 within the same cycle;
  - the next NAL starts cleanly at addr 0.

Source files
------------

// File: rtl/nalu_pkg.sv
// Constants, state encoding and small helpers shared by the Annex-B NAL unit
// reader and writer.
package nalu_pkg;

  localparam int RBSP_W = 9;

  localparam logic [23:0] SC_SHORT = 24'h000001;
  localparam logic [31:0] SC_LONG  = 32'h00000001;
  localparam logic [7:0]  SC_ZERO  = SC_LONG[31:24];
  localparam logic [7:0]  SC_ONE   = SC_LONG[7:0];
  localparam logic [7:0]  EPB_BYTE = 8'h03;

  localparam logic [4:0] NAL_TYPE_SLICE = 5'd1;
  localparam logic [4:0] NAL_TYPE_IDR   = 5'd5;
  localparam logic [4:0] NAL_TYPE_SPS   = 5'd7;
  localparam logic [4:0] NAL_TYPE_PPS   = 5'd8;

  localparam logic [7:0] NAL_FORBIDDEN_MASK = 8'h80;
  localparam logic [1:0] ZC_SAT             = 2'd2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SC   = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_TAIL = 3'd4;

  function automatic logic [7:0] nal_hdr_byte(input logic [1:0] ref_idc,
                                              input logic [4:0] unit_type);
    return {1'b0, ref_idc, unit_type};
  endfunction

  // Parameter sets (SPS/PPS) get the 4-byte start code so they can open an access unit.
  function automatic logic use_long_sc(input logic long_all, input logic [4:0] unit_type);
    return long_all || (unit_type == NAL_TYPE_SPS) || (unit_type == NAL_TYPE_PPS);
  endfunction

  function automatic logic [1:0] zc_next(input logic [1:0] zc, input logic [7:0] b);
    logic [1:0] r;
    if (b != 8'h00) begin
      r = 2'd0;
    end else if (zc == ZC_SAT) begin
      r = ZC_SAT;
    end else begin
      r = zc + 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nalu_epb_insert.sv
// Payload zero-run tracking, emulation-prevention insertion and the single
// output byte register shared by every writer state.
module nalu_epb_insert
  import nalu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic              pay_i,
  input  logic              zc_clr_i,
  input  logic              ctl_load_i,
  input  logic [7:0]        ctl_byte_i,
  input  logic              ctl_last_i,
  input  logic [RBSP_W-1:0] rbsp_data_i,
  input  logic              rbsp_valid_i,
  output logic              rbsp_ready_o,
  output logic              accept_o,
  input  logic              stream_ready_i,
  output logic [7:0]        stream_data_o,
  output logic              stream_valid_o,
  output logic              load_ok_o,
  output logic              xfer_o,
  output logic              occupied_o,
  output logic              last_o
);

  logic [1:0] zc_q, zc_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       need_epb_s;
  logic       load_s;

  assign load_ok_o  = ena_i && (!valid_q || stream_ready_i);
  assign xfer_o     = ena_i && valid_q && stream_ready_i;
  assign need_epb_s = pay_i && rbsp_valid_i && (zc_q == ZC_SAT) && (rbsp_data_i[7:0] <= EPB_BYTE);

  assign rbsp_ready_o   = pay_i && !need_epb_s && load_ok_o;
  assign accept_o       = rbsp_ready_o && rbsp_valid_i;
  assign stream_data_o  = data_q;
  assign stream_valid_o = valid_q && ena_i;
  assign occupied_o     = valid_q;
  assign last_o         = last_q;

  // A final RBSP byte of 0x00 is not the last output byte: a trailing 0x03 follows it.
  always_comb begin
    load_s = 1'b0;
    data_d = data_q;
    last_d = last_q;
    zc_d   = zc_q;
    if (pay_i) begin
      if (need_epb_s && load_ok_o) begin
        load_s = 1'b1;
        data_d = EPB_BYTE;
        last_d = 1'b0;
        zc_d   = 2'd0;
      end else if (accept_o) begin
        load_s = 1'b1;
        data_d = rbsp_data_i[7:0];
        last_d = rbsp_data_i[8] && (rbsp_data_i[7:0] != 8'h00);
        zc_d   = zc_next(zc_q, rbsp_data_i[7:0]);
      end else begin
        load_s = 1'b0;
      end
    end else if (ctl_load_i) begin
      load_s = 1'b1;
      data_d = ctl_byte_i;
      last_d = ctl_last_i;
      zc_d   = zc_clr_i ? 2'd0 : zc_q;
    end else begin
      load_s = 1'b0;
    end
    if (load_s) begin
      valid_d = 1'b1;
    end else if (xfer_o) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zc_q    <= 2'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      zc_q    <= zc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/write_nalu.sv
// Annex-B NAL unit writer: start code, header byte, then RBSP payload with
// emulation prevention, written byte-by-byte to an incrementing address.
module write_nalu
  import nalu_pkg::*;
#(
  parameter bit ALWAYS_LONG_SC = 1'b0,
  parameter int ADDR_W         = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              nal_start,
  input  logic [4:0]        nal_unit_type,
  input  logic [1:0]        nal_ref_idc,
  input  logic [RBSP_W-1:0] rbsp_data_in,
  input  logic              rbsp_valid_in,
  output logic              rbsp_ready_out,
  output logic [7:0]        stream_data_out,
  output logic              stream_valid_out,
  input  logic              stream_ready_in,
  output logic [ADDR_W-1:0] stream_mem_addr,
  output logic              busy,
  output logic              nal_done
);

  logic [2:0]        state_q, state_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [1:0]        sc_cnt_q, sc_cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        sc_zeros_s;
  logic              load_ok_s, xfer_s, accept_s, occupied_s, last_s;
  logic              pay_s, ctl_load_s, ctl_last_s, zc_clr_s;
  logic [7:0]        ctl_byte_s;

  assign sc_zeros_s = use_long_sc(ALWAYS_LONG_SC, hdr_q[4:0]) ? 2'd3 : 2'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hdr_q    <= 8'h00;
      sc_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      sc_cnt_q <= sc_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    sc_cnt_d = sc_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (nal_start && ena) begin
          hdr_d    = nal_hdr_byte(nal_ref_idc, nal_unit_type);
          sc_cnt_d = 2'd0;
          state_d  = ST_SC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SC: begin
        if (load_ok_s && (sc_cnt_q == sc_zeros_s)) begin
          state_d = ST_HDR;
        end else if (load_ok_s) begin
          sc_cnt_d = sc_cnt_q + 2'd1;
        end else begin
          state_d = ST_SC;
        end
      end
      ST_HDR: begin
        state_d = load_ok_s ? ST_PAY : ST_HDR;
      end
      ST_PAY: begin
        if (accept_s && rbsp_data_in[8]) begin
          state_d = (rbsp_data_in[7:0] == 8'h00) ? ST_TAIL : ST_IDLE;
        end else begin
          state_d = ST_PAY;
        end
      end
      ST_TAIL: begin
        state_d = load_ok_s ? ST_IDLE : ST_TAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pay_s      = 1'b0;
    ctl_load_s = 1'b0;
    ctl_byte_s = SC_ZERO;
    ctl_last_s = 1'b0;
    zc_clr_s   = 1'b0;
    case (state_q)
      ST_SC: begin
        ctl_load_s = load_ok_s;
        ctl_byte_s = (sc_cnt_q == sc_zeros_s) ? SC_ONE : SC_ZERO;
      end
      ST_HDR: begin
        ctl_load_s = load_ok_s;
        ctl_byte_s = hdr_q;
        zc_clr_s   = 1'b1;
      end
      ST_PAY: begin
        pay_s = 1'b1;
      end
      ST_TAIL: begin
        ctl_load_s = load_ok_s;
        ctl_byte_s = EPB_BYTE;
        ctl_last_s = 1'b1;
      end
      default: begin
        pay_s = 1'b0;
      end
    endcase
  end

  nalu_epb_insert u_epb (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena_i          (ena),
    .pay_i          (pay_s),
    .zc_clr_i       (zc_clr_s),
    .ctl_load_i     (ctl_load_s),
    .ctl_byte_i     (ctl_byte_s),
    .ctl_last_i     (ctl_last_s),
    .rbsp_data_i    (rbsp_data_in),
    .rbsp_valid_i   (rbsp_valid_in),
    .rbsp_ready_o   (rbsp_ready_out),
    .accept_o       (accept_s),
    .stream_ready_i (stream_ready_in),
    .stream_data_o  (stream_data_out),
    .stream_valid_o (stream_valid_out),
    .load_ok_o      (load_ok_s),
    .xfer_o         (xfer_s),
    .occupied_o     (occupied_s),
    .last_o         (last_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= {ADDR_W{1'b0}};
    end else if (xfer_s) begin
      addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      addr_q <= addr_q;
    end
  end

  assign stream_mem_addr = addr_q;
  assign busy            = (state_q != ST_IDLE) || occupied_s;
  assign nal_done        = xfer_s && last_s;

endmodule

// File: tb/tb_write_nalu.sv
// Scoreboard bench for write_nalu: a short-start-code instance and an
// always-long instance share stimulus, selected one at a time.
module tb_write_nalu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, sel, start, rbsp_valid, stream_ready;
  logic [4:0] nal_type;
  logic [1:0] nal_idc;
  logic [8:0] rbsp_data;

  logic        start0, start1, rv0, rv1;
  logic        rdy0, rdy1, v0, v1, busy0, busy1, done0, done1;
  logic [7:0]  d0, d1;
  logic [31:0] a0, a1;

  assign start0 = start && !sel;
  assign start1 = start && sel;
  assign rv0    = rbsp_valid && !sel;
  assign rv1    = rbsp_valid && sel;

  write_nalu #(.ALWAYS_LONG_SC(1'b0), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .nal_start(start0),
    .nal_unit_type(nal_type), .nal_ref_idc(nal_idc),
    .rbsp_data_in(rbsp_data), .rbsp_valid_in(rv0), .rbsp_ready_out(rdy0),
    .stream_data_out(d0), .stream_valid_out(v0), .stream_ready_in(stream_ready),
    .stream_mem_addr(a0), .busy(busy0), .nal_done(done0)
  );

  write_nalu #(.ALWAYS_LONG_SC(1'b1), .ADDR_W(32)) dut_l (
    .clk(clk), .rst_n(rst_n), .ena(ena), .nal_start(start1),
    .nal_unit_type(nal_type), .nal_ref_idc(nal_idc),
    .rbsp_data_in(rbsp_data), .rbsp_valid_in(rv1), .rbsp_ready_out(rdy1),
    .stream_data_out(d1), .stream_valid_out(v1), .stream_ready_in(stream_ready),
    .stream_mem_addr(a1), .busy(busy1), .nal_done(done1)
  );

  logic        m_rdy, m_valid, m_busy, m_done;
  logic [7:0]  m_data;
  logic [31:0] m_addr;
  assign m_rdy   = sel ? rdy1  : rdy0;
  assign m_valid = sel ? v1    : v0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;
  assign m_data  = sel ? d1    : d0;
  assign m_addr  = sel ? a1    : a0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  exp_q[$];
  logic [31:0] exp_addr;
  logic [8:0]  pay [8];
  bit          sb_off, paying, stress_on, ena_done;
  int          ena_lo_cnt, stall_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [4:0] t, input logic [1:0] r, input int n, input bit long_sc);
    int         zc;
    logic [7:0] b;
    for (int k = 0; k < (long_sc ? 3 : 2); k++) exp_q.push_back(9'h000);
    exp_q.push_back(9'h001);
    exp_q.push_back({1'b0, 1'b0, r, t});
    zc = 0;
    for (int i = 0; i < n; i++) begin
      b = pay[i][7:0];
      if (zc == 2 && b <= 8'h03) begin
        exp_q.push_back(9'h003);
        zc = 0;
      end
      exp_q.push_back({pay[i][8] && (b != 8'h00), b});
      zc = (b == 8'h00) ? ((zc == 2) ? 2 : zc + 1) : 0;
    end
    if (pay[n-1][7:0] == 8'h00) exp_q.push_back(9'h103);
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (m_busy && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("idle_reached", 32'(m_busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_nal(input logic [4:0] t, input logic [1:0] r, input int n,
                          input bit wait_first, input bit poke, input int n_feed);
    bit got;
    int cnt;
    if (wait_first) wait_idle();
    if (!sb_off) push_expected(t, r, n, sel || t == 5'd7 || t == 5'd8);
    nal_type = t;
    nal_idc  = r;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < n_feed; i++) begin
      rbsp_data  = pay[i];
      rbsp_valid = 1'b1;
      if (poke && i == 2) start = 1'b1;
      got = 1'b0;
      cnt = 0;
      while (!got && cnt < 200) begin
        @(negedge clk);
        got = m_rdy;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt++;
      end
      check_eq("feed_handshake", 32'(got), 32'd1);
      paying = 1'b1;
    end
    rbsp_valid = 1'b0;
    paying     = 1'b0;
  endtask

  task automatic end_nal();
    wait_idle();
    check_eq("addr_total", m_addr, exp_addr);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every output handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && !sb_off) begin
      if (!ena) check_eq("valid_ena_low", 32'(m_valid), 32'd0);
      if (paying && rbsp_valid && ena && !m_rdy) stall_cnt++;
      if (m_valid && stream_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("byte", 32'(m_data), 32'(exp_q[0][7:0]));
          check_eq("nal_done", 32'(m_done), 32'(exp_q[0][8]));
          check_eq("addr", m_addr, exp_addr);
          exp_q.delete(0);
          exp_addr = exp_addr + 32'd1;
        end
      end else begin
        check_eq("done_idle", 32'(m_done), 32'd0);
      end
    end
  end

  // Backpressure 1010 on the sink plus one 3-cycle ena drop mid-payload.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stress_on) begin
        stream_ready = ~stream_ready;
        if (paying && !ena_done) begin
          if (ena_lo_cnt < 3) begin
            ena = 1'b0;
            ena_lo_cnt++;
          end else begin
            ena      = 1'b1;
            ena_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; sel = 1'b0; start = 1'b0;
    rbsp_valid = 1'b0; rbsp_data = 9'h000; stream_ready = 1'b1;
    nal_type = 5'd0; nal_idc = 2'd0;
    sb_off = 1'b0; paying = 1'b0; stress_on = 1'b0; ena_done = 1'b0;
    ena_lo_cnt = 0; stall_cnt = 0; exp_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(v0), 32'd0);
    check_eq("rst_ready", 32'(rdy0), 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_addr", a0, 32'd0);
    check_eq("rst_data", 32'(d0), 32'd0);
    rst_n = 1'b1;

    // SPS with 4-byte start code, no EPB.
    pay[0] = 9'h042; pay[1] = 9'h000; pay[2] = 9'h01F; pay[3] = 9'h1E9;
    send_nal(5'd7, 2'd3, 4, 1'b1, 1'b0, 4);
    end_nal();
    check_eq("t1_addr", m_addr, 32'd9);

    // EPB before 0x01, none before 0x80.
    stall_cnt = 0;
    pay[0] = 9'h000; pay[1] = 9'h000; pay[2] = 9'h001;
    pay[3] = 9'h000; pay[4] = 9'h000; pay[5] = 9'h180;
    send_nal(5'd1, 2'd2, 6, 1'b1, 1'b0, 6);
    end_nal();
    check_eq("t2_epb_stall", 32'(stall_cnt), 32'd1);

    // All-zero payload: EPB plus trailing 0x03.
    stall_cnt = 0;
    pay[0] = 9'h000; pay[1] = 9'h000; pay[2] = 9'h000; pay[3] = 9'h100;
    send_nal(5'd5, 2'd3, 4, 1'b1, 1'b0, 4);
    end_nal();
    check_eq("t3_epb_stall", 32'(stall_cnt), 32'd1);

    // Same NAL under backpressure and an ena drop.
    stress_on = 1'b1; ena_done = 1'b0; ena_lo_cnt = 0;
    send_nal(5'd5, 2'd3, 4, 1'b1, 1'b0, 4);
    end_nal();
    stress_on = 1'b0; stream_ready = 1'b1; ena = 1'b1;
    check_eq("t4_addr", m_addr, 32'd40);

    // Always-long instance: ignored mid-NAL start, then back-to-back NALs.
    sel = 1'b1;
    exp_addr = 32'd0;
    pay[0] = 9'h011; pay[1] = 9'h022; pay[2] = 9'h133;
    send_nal(5'd1, 2'd2, 3, 1'b1, 1'b1, 3);
    send_nal(5'd1, 2'd2, 3, 1'b0, 1'b0, 3);
    end_nal();
    check_eq("t5_addr", m_addr, 32'd16);

    // Reset mid-payload, then a clean NAL from address 0.
    sel = 1'b0;
    sb_off = 1'b1;
    pay[0] = 9'h000; pay[1] = 9'h000; pay[2] = 9'h001;
    pay[3] = 9'h000; pay[4] = 9'h000; pay[5] = 9'h180;
    send_nal(5'd1, 2'd2, 6, 1'b1, 1'b0, 3);
    check_eq("pre_rst_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(v0), 32'd0);
    check_eq("mid_rst_ready", 32'(rdy0), 32'd0);
    check_eq("mid_rst_busy", 32'(busy0), 32'd0);
    check_eq("mid_rst_done", 32'(done0), 32'd0);
    check_eq("mid_rst_addr", a0, 32'd0);
    check_eq("mid_rst_data", 32'(d0), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_addr = 32'd0;
    sb_off = 1'b0;
    pay[0] = 9'h042; pay[1] = 9'h000; pay[2] = 9'h01F; pay[3] = 9'h1E9;
    send_nal(5'd7, 2'd3, 4, 1'b1, 1'b0, 4);
    end_nal();
    check_eq("t6_addr", m_addr, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
